// File: rtl/dllp_fc_scheduler.sv
// ============================================================================
// dllp_fc_scheduler : tracks RX TLP events and requests Ack/Nak + UpdateFC bursts
// Rev 1.0
// ============================================================================
`default_nettype none

module dllp_fc_scheduler #(
  parameter int UPDATE_PERIOD = 1024,
  parameter int ACK_THRESHOLD = 4,
  parameter int TIMER_WIDTH   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        link_up_i,
  input  logic        tlp_valid_i,
  input  logic        tlp_good_i,
  input  logic [11:0] tlp_seq_i,
  input  logic [1:0]  tlp_type_i,
  input  logic        tlp_has_data_i,
  input  logic [9:0]  tlp_len_dw_i,
  output logic        start_flow_control_o,
  input  logic        start_flow_control_ack_i,
  output logic [15:0] next_transmit_seq_o,
  output logic        tlp_nullified_o,
  output logic [7:0]  ph_credits_consumed_o,
  output logic [11:0] pd_credits_consumed_o,
  output logic [7:0]  nph_credits_consumed_o,
  output logic [11:0] npd_credits_consumed_o
);

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(UPDATE_PERIOD - 1);
  localparam logic [7:0]             ACK_THR    = 8'(ACK_THRESHOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   start_q;
  logic [11:0]            snap_seq_q;
  logic                   snap_nak_q;
  logic [7:0]             snap_ph_q, snap_nph_q;
  logic [11:0]            snap_pd_q, snap_npd_q;

  logic [11:0]            seq_q, seq_d;
  logic [7:0]             ph_q, ph_d, nph_q, nph_d;
  logic [11:0]            pd_q, pd_d, npd_q, npd_d;
  logic [7:0]             pending_q, pending_d;
  logic                   nak_q, nak_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;

  logic                   trigger;
  logic [10:0]            len_p3;
  logic [11:0]            data_cred;

  // A zero length field means the maximum 1024 DW payload, i.e. 256 credits.
  assign len_p3    = {1'b0, tlp_len_dw_i} + 11'd3;
  assign data_cred = (tlp_len_dw_i == 10'd0) ? 12'd256 : {3'b000, len_p3[10:2]};

  assign trigger = (state_q == IDLE) && link_up_i &&
                   ((timer_q == TIMER_LAST) || (pending_q >= ACK_THR) || nak_q);

  always_comb begin
    seq_d     = seq_q;
    ph_d      = ph_q;
    pd_d      = pd_q;
    nph_d     = nph_q;
    npd_d     = npd_q;
    pending_d = pending_q;
    nak_d     = nak_q;
    timer_d   = timer_q;
    if (!link_up_i) begin
      seq_d     = 12'hFFF;
      ph_d      = 8'd0;
      pd_d      = 12'd0;
      nph_d     = 8'd0;
      npd_d     = 12'd0;
      pending_d = 8'd0;
      nak_d     = 1'b0;
      timer_d   = '0;
    end else begin
      if (trigger) begin
        pending_d = 8'd0;
        nak_d     = 1'b0;
        timer_d   = '0;
      end else if (state_q == IDLE) begin
        timer_d = timer_q + 1'b1;
      end
      // Event is applied after the trigger clear so it survives into the next update.
      if (tlp_valid_i) begin
        if (tlp_good_i) begin
          seq_d     = tlp_seq_i;
          pending_d = (pending_d == 8'hFF) ? 8'hFF : pending_d + 8'd1;
          case (tlp_type_i)
            2'd0: begin
              ph_d = ph_q + 8'd1;
              if (tlp_has_data_i) pd_d = pd_q + data_cred;
            end
            2'd1: begin
              nph_d = nph_q + 8'd1;
              if (tlp_has_data_i) npd_d = npd_q + data_cred;
            end
            default: ;
          endcase
        end else begin
          nak_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seq_q     <= 12'hFFF;
      ph_q      <= 8'd0;
      pd_q      <= 12'd0;
      nph_q     <= 8'd0;
      npd_q     <= 12'd0;
      pending_q <= 8'd0;
      nak_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      seq_q     <= seq_d;
      ph_q      <= ph_d;
      pd_q      <= pd_d;
      nph_q     <= nph_d;
      npd_q     <= npd_d;
      pending_q <= pending_d;
      nak_q     <= nak_d;
      timer_q   <= timer_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      snap_seq_q <= 12'hFFF;
      snap_nak_q <= 1'b0;
      snap_ph_q  <= 8'd0;
      snap_pd_q  <= 12'd0;
      snap_nph_q <= 8'd0;
      snap_npd_q <= 12'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q    <= REQ;
            start_q    <= 1'b1;
            snap_seq_q <= seq_q;
            snap_nak_q <= nak_q;
            snap_ph_q  <= ph_q;
            snap_pd_q  <= pd_q;
            snap_nph_q <= nph_q;
            snap_npd_q <= npd_q;
          end
        end
        REQ: begin
          if (start_flow_control_ack_i) begin
            state_q <= DROP;
            start_q <= 1'b0;
          end
        end
        DROP: begin
          if (!start_flow_control_ack_i) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign start_flow_control_o   = start_q;
  assign next_transmit_seq_o    = {4'h0, snap_seq_q};
  assign tlp_nullified_o        = snap_nak_q;
  assign ph_credits_consumed_o  = snap_ph_q;
  assign pd_credits_consumed_o  = snap_pd_q;
  assign nph_credits_consumed_o = snap_nph_q;
  assign npd_credits_consumed_o = snap_npd_q;

endmodule

`default_nettype wire

// File: tb/tb_dllp_fc_scheduler.sv
// ============================================================================
// tb_dllp_fc_scheduler : directed self-checking bench for dllp_fc_scheduler
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dllp_fc_scheduler;

  localparam int PERIOD = 64;
  localparam int THRESH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_up = 1'b0;
  logic        tlp_valid = 1'b0;
  logic        tlp_good = 1'b0;
  logic [11:0] tlp_seq = 12'd0;
  logic [1:0]  tlp_type = 2'd0;
  logic        tlp_has_data = 1'b0;
  logic [9:0]  tlp_len = 10'd0;
  logic        ack = 1'b0;
  logic        start;
  logic [15:0] seq_o;
  logic        nullified;
  logic [7:0]  ph, nph;
  logic [11:0] pd, npd;

  int pass_cnt = 0;
  int total_cnt = 0;

  dllp_fc_scheduler #(
    .UPDATE_PERIOD(PERIOD),
    .ACK_THRESHOLD(THRESH),
    .TIMER_WIDTH(8)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .link_up_i(link_up),
    .tlp_valid_i(tlp_valid),
    .tlp_good_i(tlp_good),
    .tlp_seq_i(tlp_seq),
    .tlp_type_i(tlp_type),
    .tlp_has_data_i(tlp_has_data),
    .tlp_len_dw_i(tlp_len),
    .start_flow_control_o(start),
    .start_flow_control_ack_i(ack),
    .next_transmit_seq_o(seq_o),
    .tlp_nullified_o(nullified),
    .ph_credits_consumed_o(ph),
    .pd_credits_consumed_o(pd),
    .nph_credits_consumed_o(nph),
    .npd_credits_consumed_o(npd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tlp(input logic good, input logic [11:0] seq, input logic [1:0] typ,
                          input logic hd, input logic [9:0] len);
    tlp_valid    = 1'b1;
    tlp_good     = good;
    tlp_seq      = seq;
    tlp_type     = typ;
    tlp_has_data = hd;
    tlp_len      = len;
    tick();
    tlp_valid    = 1'b0;
  endtask

  task automatic do_handshake();
    int n;
    n = 0;
    ack = 1'b1;
    tick();
    while (start === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total_cnt++;
    if (start !== 1'b0) $display("FAIL handshake_drop: start=%b expected 0", start);
    else pass_cnt++;
    ack = 1'b0;
    tick();
  endtask

  task automatic link_cycle();
    link_up = 1'b0;
    tick();
    link_up = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total_cnt++;
    if (start !== 1'b0) $display("FAIL reset_start: got %b expected 0", start);
    else pass_cnt++;
    total_cnt++;
    if (seq_o !== 16'h0FFF) $display("FAIL reset_seq: got %h expected 0fff", seq_o);
    else pass_cnt++;
    total_cnt++;
    if ({nullified, ph, pd, nph, npd} !== 41'd0)
      $display("FAIL reset_snap: got nul=%b ph=%0d pd=%0d nph=%0d npd=%0d expected all 0",
               nullified, ph, pd, nph, npd);
    else pass_cnt++;
  endtask

  task automatic test_timer_update();
    int cnt;
    #2 rst_n = 1'b1;
    tick();
    link_up = 1'b1;
    cnt = 0;
    while (start !== 1'b1 && cnt < 2 * PERIOD) begin
      tick();
      cnt++;
    end
    total_cnt++;
    if (cnt !== PERIOD) $display("FAIL timer_latency: got %0d cycles expected %0d", cnt, PERIOD);
    else pass_cnt++;
    total_cnt++;
    if (seq_o !== 16'h0FFF || nullified !== 1'b0)
      $display("FAIL timer_snap_seq: got seq=%h nul=%b expected 0fff 0", seq_o, nullified);
    else pass_cnt++;
    total_cnt++;
    if ({ph, pd, nph, npd} !== 40'd0)
      $display("FAIL timer_snap_cred: got ph=%0d pd=%0d nph=%0d npd=%0d expected 0", ph, pd, nph, npd);
    else pass_cnt++;
  endtask

  task automatic test_ack_threshold();
    do_handshake();
    link_cycle();
    send_tlp(1'b1, 12'd0, 2'd0, 1'b1, 10'd1);
    send_tlp(1'b1, 12'd1, 2'd0, 1'b1, 10'd4);
    send_tlp(1'b1, 12'd2, 2'd0, 1'b1, 10'd5);
    send_tlp(1'b1, 12'd3, 2'd0, 1'b1, 10'd0);
    total_cnt++;
    if (start !== 1'b0) $display("FAIL thresh_not_yet: start=%b expected 0", start);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (start !== 1'b1) $display("FAIL thresh_start: start=%b expected 1", start);
    else pass_cnt++;
    total_cnt++;
    if (seq_o !== 16'h0003 || nullified !== 1'b0)
      $display("FAIL thresh_seq: got seq=%h nul=%b expected 0003 0", seq_o, nullified);
    else pass_cnt++;
    total_cnt++;
    if (ph !== 8'd4 || pd !== 12'd260 || nph !== 8'd0 || npd !== 12'd0)
      $display("FAIL thresh_cred: got ph=%0d pd=%0d nph=%0d npd=%0d expected 4 260 0 0", ph, pd, nph, npd);
    else pass_cnt++;
  endtask

  task automatic test_nak();
    do_handshake();
    link_cycle();
    send_tlp(1'b1, 12'd0, 2'd1, 1'b1, 10'd1);
    send_tlp(1'b0, 12'd9, 2'd0, 1'b1, 10'd8);
    total_cnt++;
    if (start !== 1'b0) $display("FAIL nak_early: start=%b expected 0", start);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (start !== 1'b1 || nullified !== 1'b1 || seq_o !== 16'h0000)
      $display("FAIL nak_snap: got start=%b nul=%b seq=%h expected 1 1 0000", start, nullified, seq_o);
    else pass_cnt++;
    total_cnt++;
    if (nph !== 8'd1 || npd !== 12'd1 || ph !== 8'd0 || pd !== 12'd0)
      $display("FAIL nak_cred: got nph=%0d npd=%0d ph=%0d pd=%0d expected 1 1 0 0", nph, npd, ph, pd);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_handshake();
    link_cycle();
    for (int i = 0; i < 4; i++) send_tlp(1'b1, 12'(i), 2'd0, 1'b1, 10'd4);
    // This event coincides with the trigger edge.
    send_tlp(1'b1, 12'd4, 2'd0, 1'b1, 10'd4);
    total_cnt++;
    if (start !== 1'b1 || seq_o !== 16'h0003 || ph !== 8'd4 || pd !== 12'd4)
      $display("FAIL b2b_first: got start=%b seq=%h ph=%0d pd=%0d expected 1 0003 4 4", start, seq_o, ph, pd);
    else pass_cnt++;
    do_handshake();
    send_tlp(1'b1, 12'd5, 2'd0, 1'b1, 10'd4);
    send_tlp(1'b1, 12'd6, 2'd0, 1'b1, 10'd4);
    send_tlp(1'b1, 12'd7, 2'd0, 1'b1, 10'd4);
    total_cnt++;
    if (start !== 1'b0) $display("FAIL b2b_wait: start=%b expected 0", start);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (start !== 1'b1 || seq_o !== 16'h0007 || ph !== 8'd8 || pd !== 12'd8)
      $display("FAIL b2b_second: got start=%b seq=%h ph=%0d pd=%0d expected 1 0007 8 8", start, seq_o, ph, pd);
    else pass_cnt++;
  endtask

  task automatic test_ack_hold();
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (start !== 1'b1) $display("FAIL hold_req: cycle %0d start=%b expected 1", i, start);
      else pass_cnt++;
    end
    ack = 1'b1;
    send_tlp(1'b0, 12'd0, 2'd0, 1'b0, 10'd0);
    total_cnt++;
    if (start !== 1'b0) $display("FAIL hold_drop: start=%b expected 0", start);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (start !== 1'b0) $display("FAIL hold_noretrig: cycle %0d start=%b expected 0", i, start);
      else pass_cnt++;
    end
    total_cnt++;
    if (seq_o !== 16'h0007 || nullified !== 1'b0 || ph !== 8'd8)
      $display("FAIL hold_stable: got seq=%h nul=%b ph=%0d expected 0007 0 8", seq_o, nullified, ph);
    else pass_cnt++;
    ack = 1'b0;
    tick();
    total_cnt++;
    if (start !== 1'b0) $display("FAIL hold_idle: start=%b expected 0", start);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (start !== 1'b1 || nullified !== 1'b1 || seq_o !== 16'h0007 || ph !== 8'd8)
      $display("FAIL hold_retrig: got start=%b nul=%b seq=%h ph=%0d expected 1 1 0007 8",
               start, nullified, seq_o, ph);
    else pass_cnt++;
  endtask

  task automatic test_wrap_and_reset();
    int n;
    do_handshake();
    link_cycle();
    for (int i = 0; i < 300; i++) send_tlp(1'b1, 12'(i), 2'd0, 1'b1, 10'd16);
    do_handshake();
    n = 0;
    while (start !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total_cnt++;
    if (start !== 1'b1) $display("FAIL wrap_start: start=%b expected 1", start);
    else pass_cnt++;
    total_cnt++;
    if (ph !== 8'd44 || pd !== 12'd1200 || seq_o !== 16'h012B)
      $display("FAIL wrap_cred: got ph=%0d pd=%0d seq=%h expected 44 1200 012b", ph, pd, seq_o);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (start !== 1'b0 || seq_o !== 16'h0FFF || ph !== 8'd0 || pd !== 12'd0)
      $display("FAIL async_reset: got start=%b seq=%h ph=%0d pd=%0d expected 0 0fff 0 0", start, seq_o, ph, pd);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_timer_update();
    test_ack_threshold();
    test_nak();
    test_back_to_back();
    test_ack_hold();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
